// File: rtl/tdm_demux.sv
// -----------------------------------------------------------------------------
// tdm_demux
//
// Time-division demultiplexer. A shared serial word bus carries one WIDTH-bit
// word per channel slot; the word for channel 0 is flagged with in_sync. Each
// accepted word is steered into its own registered output channel. A slot
// counter holds frame lock, and framing errors are reported as single-cycle
// pulses.
//
// Parameters:
//   WIDTH    - bits per data word
//   CHANNELS - number of output channels (>= 2, any value, not only powers of 2)
//   SEL_W    - slot counter width, derived from CHANNELS (do not override)
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   in_valid   in   in_data / in_sync are valid this cycle
//   in_data    in   incoming word
//   in_sync    in   marks the channel-0 word of a frame (qualified by in_valid)
//   out        out  channel k at bits [k*WIDTH +: WIDTH], registered
//   out_strobe out  one-hot pulse on the channel written this cycle
//   frame_done out  pulse when channel CHANNELS-1 is written
//   locked     out  high while frame lock is held
//   sync_err   out  pulse on a framing error
//   err_count  out  (only with TDM_DEMUX_ERRCNT_EN) saturating 8-bit count of
//                   sync_err pulses, cleared by reset only
//
// Optional feature macro: TDM_DEMUX_ERRCNT_EN
// -----------------------------------------------------------------------------
module tdm_demux #(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 4,
   parameter int SEL_W    = $clog2(CHANNELS)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_valid,
   input  logic [WIDTH-1:0]            in_data,
   input  logic                        in_sync,
   output logic [CHANNELS*WIDTH-1:0]   out,
   output logic [CHANNELS-1:0]         out_strobe,
   output logic                        frame_done,
   output logic                        locked,
   output logic                        sync_err
`ifdef TDM_DEMUX_ERRCNT_EN
   ,
   output logic [7:0]                  err_count
`endif
);

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   // Explicit compare against the last slot lets CHANNELS be any value >= 2.
   localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(CHANNELS - 1);

   state_t                      state_q, state_d;
   logic [SEL_W-1:0]            slot_q, slot_d;
   logic [CHANNELS*WIDTH-1:0]   out_q, out_d;
   logic [CHANNELS-1:0]         strobe_q, strobe_d;
   logic                        frame_done_q, frame_done_d;
   logic                        sync_err_q, sync_err_d;

   // Write request produced by the framing decision below.
   logic                        wr_en;
   logic [SEL_W-1:0]            wr_sel;

   // --------------------------------------------------------------------------
   // Next-state and output decode
   // --------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      slot_d       = slot_q;
      out_d        = out_q;
      strobe_d     = '0;
      frame_done_d = 1'b0;
      sync_err_d   = 1'b0;
      wr_en        = 1'b0;
      wr_sel       = '0;

      if (in_valid) begin
         unique case (state_q)
            HUNT: begin
               // Words before the first sync are dropped silently.
               if (in_sync) begin
                  wr_en   = 1'b1;
                  wr_sel  = '0;
                  slot_d  = SEL_W'(1);
                  state_d = LOCKED;
               end
            end

            LOCKED: begin
               if (in_sync) begin
                  // Sync always restarts the frame at channel 0; arriving
                  // anywhere but slot 0 is an early sync (resync, still locked).
                  wr_en      = 1'b1;
                  wr_sel     = '0;
                  slot_d     = SEL_W'(1);
                  sync_err_d = (slot_q != '0);
               end else if (slot_q == '0) begin
                  // Expected a sync word and did not get one: lose lock.
                  sync_err_d = 1'b1;
                  slot_d     = '0;
                  state_d    = HUNT;
               end else begin
                  wr_en  = 1'b1;
                  wr_sel = slot_q;
                  slot_d = (slot_q == LAST_SLOT) ? '0 : slot_q + SEL_W'(1);
               end
            end

            default: begin
               state_d = HUNT;
               slot_d  = '0;
            end
         endcase
      end

      if (wr_en) begin
         for (int k = 0; k < CHANNELS; k++) begin
            if (wr_sel == SEL_W'(k)) begin
               out_d[k*WIDTH +: WIDTH] = in_data;
               strobe_d[k]             = 1'b1;
            end
         end
         // Only a write into the last channel completes a frame; a resync
         // writes channel 0 and therefore never reports the partial frame.
         frame_done_d = (wr_sel == LAST_SLOT);
      end
   end

   // --------------------------------------------------------------------------
   // State and output registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= HUNT;
         slot_q       <= '0;
         out_q        <= '0;
         strobe_q     <= '0;
         frame_done_q <= 1'b0;
         sync_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         slot_q       <= slot_d;
         out_q        <= out_d;
         strobe_q     <= strobe_d;
         frame_done_q <= frame_done_d;
         sync_err_q   <= sync_err_d;
      end
   end

   assign out        = out_q;
   assign out_strobe = strobe_q;
   assign frame_done = frame_done_q;
   assign sync_err   = sync_err_q;
   assign locked     = (state_q == LOCKED);

`ifdef TDM_DEMUX_ERRCNT_EN
   // --------------------------------------------------------------------------
   // Saturating framing-error counter
   // --------------------------------------------------------------------------
   logic [7:0] err_cnt_q, err_cnt_d;

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (sync_err_d && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_cnt_q <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_tdm_demux.sv
// -----------------------------------------------------------------------------
// tb_tdm_demux
//
// Directed bench for tdm_demux (WIDTH=16, CHANNELS=4). A frame-level model
// (channel array, lock flag, slot index) predicts every output; a compare
// process checks the DUT against it on every falling edge, and literal
// expectations pin key points of each scenario.
// -----------------------------------------------------------------------------
module tb_tdm_demux;

   localparam int W  = 16;
   localparam int CH = 4;

   logic              clk;
   logic              reset;
   logic              in_valid;
   logic [W-1:0]      in_data;
   logic              in_sync;
   logic [CH*W-1:0]   out;
   logic [CH-1:0]     out_strobe;
   logic              frame_done;
   logic              locked;
   logic              sync_err;
`ifdef TDM_DEMUX_ERRCNT_EN
   logic [7:0]        err_count;
`endif

   int checks = 0;
   int errors = 0;

   tdm_demux #(.WIDTH(W), .CHANNELS(CH)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_sync    (in_sync),
      .out        (out),
      .out_strobe (out_strobe),
      .frame_done (frame_done),
      .locked     (locked),
      .sync_err   (sync_err)
`ifdef TDM_DEMUX_ERRCNT_EN
      ,
      .err_count  (err_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [CH*W-1:0] act, input logic [CH*W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- frame-level model ----------------
   logic [W-1:0]  ch_m [CH];
   bit            lock_m;
   int            slot_m;
   logic [CH-1:0] strobe_m;
   bit            fd_m;
   bit            err_m;
   int            errcnt_m;

   function automatic logic [CH*W-1:0] packed_m();
      logic [CH*W-1:0] v;
      for (int k = 0; k < CH; k++) v[k*W +: W] = ch_m[k];
      return v;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < CH; k++) ch_m[k] = '0;
         lock_m = 0; slot_m = 0; strobe_m = '0; fd_m = 0; err_m = 0; errcnt_m = 0;
      end else begin
         int wr;
         wr = -1;
         strobe_m = '0; fd_m = 0; err_m = 0;
         if (in_valid) begin
            if (!lock_m) begin
               if (in_sync) begin wr = 0; slot_m = 1; lock_m = 1; end
            end else if (in_sync) begin
               if (slot_m != 0) err_m = 1;
               wr = 0; slot_m = 1;
            end else if (slot_m == 0) begin
               err_m = 1; lock_m = 0;
            end else begin
               wr = slot_m; slot_m = (slot_m + 1) % CH;
            end
         end
         if (wr >= 0) begin
            ch_m[wr] = in_data;
            strobe_m[wr] = 1'b1;
            fd_m = (wr == CH - 1);
         end
         if (err_m && errcnt_m < 255) errcnt_m++;
      end
   end

   // ---------------- cycle compare ----------------
   always @(negedge clk) begin
      chk("out",        out,                    packed_m());
      chk("out_strobe", {60'd0, out_strobe},    {60'd0, strobe_m});
      chk("frame_done", {63'd0, frame_done},    {63'd0, fd_m});
      chk("locked",     {63'd0, locked},        {63'd0, lock_m});
      chk("sync_err",   {63'd0, sync_err},      {63'd0, err_m});
`ifdef TDM_DEMUX_ERRCNT_EN
      chk("err_count",  {56'd0, err_count},     64'(errcnt_m));
`endif
   end

   // ---------------- stimulus ----------------
   task automatic drive(input bit v, input bit s, input logic [W-1:0] d);
      @(negedge clk);
      in_valid = v; in_sync = s; in_data = d;
   endtask

   // Move to just after the next rising edge to inspect its result.
   task automatic after_edge();
      @(posedge clk); #1;
   endtask

   initial begin
      in_valid = 0; in_sync = 0; in_data = '0;
      reset = 0;
      #1 reset = 1;
      #1;
      chk("rst_out",    out, 64'd0);
      chk("rst_locked", {63'd0, locked}, 64'd0);
      repeat (2) @(negedge clk);
      reset = 0;

      // Hunt drop
      drive(1, 0, 16'hAAAA);
      drive(1, 0, 16'hBBBB);
      after_edge();
      chk("hunt_out",    out, 64'd0);
      chk("hunt_strobe", {60'd0, out_strobe}, 64'd0);
      chk("hunt_err",    {63'd0, sync_err}, 64'd0);
      chk("hunt_locked", {63'd0, locked}, 64'd0);

      // Lock and fill
      drive(1, 1, 16'h1111);
      after_edge();
      chk("fill_str0",   {60'd0, out_strobe}, 64'b0001);
      chk("fill_lock",   {63'd0, locked}, 64'd1);
      drive(1, 0, 16'h2222);
      after_edge();
      chk("fill_str1",   {60'd0, out_strobe}, 64'b0010);
      drive(1, 0, 16'h3333);
      after_edge();
      chk("fill_str2",   {60'd0, out_strobe}, 64'b0100);
      drive(1, 0, 16'h4444);
      after_edge();
      chk("fill_str3",   {60'd0, out_strobe}, 64'b1000);
      chk("fill_fd",     {63'd0, frame_done}, 64'd1);
      chk("fill_out",    out, 64'h4444_3333_2222_1111);

      // Gaps and wrap over two frames
      drive(0, 1, 16'hDEAD);
      drive(1, 1, 16'h1010);
      drive(0, 0, 16'hBEEF);
      drive(1, 0, 16'h2020);
      drive(0, 1, 16'hFFFF);
      drive(0, 0, 16'h0000);
      drive(1, 0, 16'h3030);
      drive(1, 0, 16'h4040);
      drive(0, 0, 16'h0000);
      drive(1, 1, 16'hA1A1);
      drive(1, 0, 16'hB2B2);
      drive(0, 0, 16'h0000);
      drive(1, 0, 16'hC3C3);
      drive(1, 0, 16'hD4D4);
      after_edge();
      chk("wrap_out",    out, 64'hD4D4_C3C3_B2B2_A1A1);
      chk("wrap_fd",     {63'd0, frame_done}, 64'd1);

      // Early sync at slot 2
      drive(1, 1, 16'h0100);
      drive(1, 0, 16'h0200);
      drive(1, 1, 16'h5555);
      after_edge();
      chk("early_err",   {63'd0, sync_err}, 64'd1);
      chk("early_fd",    {63'd0, frame_done}, 64'd0);
      chk("early_out",   out, 64'hD4D4_C3C3_0200_5555);
      chk("early_lock",  {63'd0, locked}, 64'd1);
      drive(1, 0, 16'h0777);
      drive(1, 0, 16'h0888);
      after_edge();
      chk("early_next",  out, 64'hD4D4_0888_0777_5555);
      drive(1, 0, 16'h0999);

      // Missing sync at slot 0
      drive(1, 0, 16'h6666);
      after_edge();
      chk("miss_err",    {63'd0, sync_err}, 64'd1);
      chk("miss_lock",   {63'd0, locked}, 64'd0);
      chk("miss_out",    out, 64'h0999_0888_0777_5555);
      drive(1, 1, 16'h7777);
      after_edge();
      chk("relock",      {63'd0, locked}, 64'd1);
      chk("relock_out",  out, 64'h0999_0888_0777_7777);

      // Async reset mid-frame
      drive(1, 0, 16'h1234);
      drive(0, 0, 16'h0000);
      @(posedge clk); #3;
      reset = 1;
      #1;
      chk("arst_out",    out, 64'd0);
      chk("arst_strobe", {60'd0, out_strobe}, 64'd0);
      chk("arst_lock",   {63'd0, locked}, 64'd0);
      chk("arst_fd",     {63'd0, frame_done}, 64'd0);
      chk("arst_err",    {63'd0, sync_err}, 64'd0);
`ifdef TDM_DEMUX_ERRCNT_EN
      chk("arst_cnt",    {56'd0, err_count}, 64'd0);
`endif
      @(negedge clk);
      reset = 0;

      // 300 forced errors: repeated sync words after lock are early syncs
      drive(1, 1, 16'h0001);
      for (int i = 0; i < 300; i++) drive(1, 1, 16'(i));
      after_edge();
      chk("sat_err",     {63'd0, sync_err}, 64'd1);
`ifdef TDM_DEMUX_ERRCNT_EN
      chk("sat_cnt",     {56'd0, err_count}, 64'd255);
`endif
      drive(0, 0, 16'h0000);
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
